// File: rtl/fsc_pkg.sv
// Shared types and helpers for the frame swap controller.
//   fsc_state_e : controller FSM states
//   IDX_W       : width of a buffer index
//   free_idx()  : returns the third index of {0,1,2} given two distinct ones
package fsc_pkg;

  localparam int unsigned IDX_W = 2;

  typedef enum logic [1:0] {
    S_START    = 2'd0,
    S_RENDER   = 2'd1,
    S_WAIT_VBL = 2'd2
  } fsc_state_e;

  // Indices 0+1+2 sum to 3, so the missing one is 3 - a - b.
  function automatic logic [IDX_W-1:0] free_idx(input logic [IDX_W-1:0] a,
                                                input logic [IDX_W-1:0] b);
    return IDX_W'(2'd3 - a - b);
  endfunction

endpackage

// File: rtl/frame_swap_controller_if.sv
// Bus bundle between the frame swap controller and its surroundings
// (VGA timing, GPU handshake, frame buffer ports, pixel and statistics out).
//   slave  : the controller side
//   master : the environment side (VGA controller, GPU, frame buffers)
interface frame_swap_controller_if #(
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned NUM_BUFFERS = 2,
  parameter int unsigned STAT_W      = 16
);

  logic                               vga_vs;
  logic                               vga_blank;
  logic                               gpu_we;
  logic                               gpu_done;
  logic [NUM_BUFFERS*DATA_W-1:0]      buf_rd_data;
  logic [NUM_BUFFERS-1:0]             buf_we;
  logic                               gpu_start;
  logic [fsc_pkg::IDX_W-1:0]          write_idx;
  logic [fsc_pkg::IDX_W-1:0]          disp_idx;
  logic [DATA_W-1:0]                  vga_r;
  logic [DATA_W-1:0]                  vga_g;
  logic [DATA_W-1:0]                  vga_b;
  logic [STAT_W-1:0]                  frame_count;
  logic [STAT_W-1:0]                  drop_count;

  modport slave (
    input  vga_vs, vga_blank, gpu_we, gpu_done, buf_rd_data,
    output buf_we, gpu_start, write_idx, disp_idx,
           vga_r, vga_g, vga_b, frame_count, drop_count
  );

  modport master (
    output vga_vs, vga_blank, gpu_we, gpu_done, buf_rd_data,
    input  buf_we, gpu_start, write_idx, disp_idx,
           vga_r, vga_g, vga_b, frame_count, drop_count
  );

endinterface

// File: rtl/fsc_pixel_mux.sv
// Selects the scan-out buffer's read data and blanks it outside the active area.
//   rd_data_i : packed read data, buffer i at [i*DATA_W +: DATA_W]
//   sel_i     : index of the buffer being displayed
//   blank_i   : 1 = active display region
//   pix_c     : gated pixel (combinational)
module fsc_pixel_mux
  import fsc_pkg::*;
#(
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned NUM_BUFFERS = 2
) (
  input  logic [NUM_BUFFERS*DATA_W-1:0] rd_data_i,
  input  logic [IDX_W-1:0]              sel_i,
  input  logic                          blank_i,
  output logic [DATA_W-1:0]             pix_c
);

  // Loop compare keeps an out-of-range index from slicing past the bus.
  always_comb begin
    pix_c = '0;
    for (int unsigned i = 0; i < NUM_BUFFERS; i++) begin
      if (blank_i && (sel_i == IDX_W'(i))) pix_c = rd_data_i[i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/frame_swap_controller.sv
// Double/triple frame buffer director: owns display/write/ready roles, the
// gpu_start/gpu_done handshake, vblank-synchronised swaps, write-enable
// steering and the blanked pixel path to the VGA outputs.
//   Clk   : system clock (rising edge)
//   Reset : synchronous active-low reset
//   bus   : frame_swap_controller_if.slave (VGA, GPU, buffer and stats signals)
// Build option: define FRAME_STATS_EN to implement frame_count/drop_count;
// otherwise both read 0 and no counter flops exist.
module frame_swap_controller
  import fsc_pkg::*;
#(
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned NUM_BUFFERS = 2,
  parameter int unsigned STAT_W      = 16
) (
  input  logic                    Clk,
  input  logic                    Reset,
  frame_swap_controller_if.slave  bus
);

  localparam bit TRIPLE = (NUM_BUFFERS == 3);

  if ((NUM_BUFFERS != 2) && (NUM_BUFFERS != 3)) begin : g_bad_cfg
    $error("frame_swap_controller: NUM_BUFFERS must be 2 or 3");
  end

  fsc_state_e       state_q, state_d;
  logic [IDX_W-1:0] disp_q, disp_d;
  logic [IDX_W-1:0] write_q, write_d;
  logic [IDX_W-1:0] ready_q, ready_d;
  logic             ready_valid_q, ready_valid_d;
  logic             gpu_start_q, gpu_start_d;
  logic             vs_q;
  logic             vbl;
  logic             frame_inc;
  logic             drop_inc;
  logic [NUM_BUFFERS-1:0] buf_we_c;
  logic [DATA_W-1:0]      pix_c;

  // vs_q resets high so a vga_vs already high at reset release is not an edge.
  assign vbl = bus.vga_vs & ~vs_q;

  // State register.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q       <= S_START;
      disp_q        <= IDX_W'(0);
      write_q       <= IDX_W'(1);
      ready_q       <= IDX_W'(2);
      ready_valid_q <= 1'b0;
      gpu_start_q   <= 1'b0;
      vs_q          <= 1'b1;
    end else begin
      state_q       <= state_d;
      disp_q        <= disp_d;
      write_q       <= write_d;
      ready_q       <= ready_d;
      ready_valid_q <= ready_valid_d;
      gpu_start_q   <= gpu_start_d;
      vs_q          <= bus.vga_vs;
    end
  end

  // Next-state logic; in triple mode the vblank promotion is applied first
  // so a gpu_done in the same cycle sees the updated roles.
  always_comb begin
    state_d       = state_q;
    disp_d        = disp_q;
    write_d       = write_q;
    ready_d       = ready_q;
    ready_valid_d = ready_valid_q;
    gpu_start_d   = 1'b0;
    frame_inc     = 1'b0;
    drop_inc      = 1'b0;

    if (TRIPLE && vbl && ready_valid_q) begin
      disp_d        = ready_q;
      ready_d       = disp_q;
      ready_valid_d = 1'b0;
      frame_inc     = 1'b1;
    end

    case (state_q)
      S_START: begin
        gpu_start_d = 1'b1;
        state_d     = S_RENDER;
      end
      S_RENDER: begin
        if (bus.gpu_done) begin
          if (TRIPLE) begin
            if (!ready_valid_d) begin
              ready_d       = write_q;
              ready_valid_d = 1'b1;
              write_d       = free_idx(disp_d, write_q);
            end else begin
              // Newest frame replaces the unshown one, whose buffer is reused.
              write_d  = ready_d;
              ready_d  = write_q;
              drop_inc = 1'b1;
            end
            state_d = S_START;
          end else begin
            state_d = S_WAIT_VBL;
          end
        end
      end
      S_WAIT_VBL: begin
        if (vbl) begin
          disp_d    = write_q;
          write_d   = disp_q;
          frame_inc = 1'b1;
          state_d   = S_START;
        end
      end
      default: state_d = S_START;
    endcase
  end

  // Write enables: only the write buffer, and never while a finished frame waits.
  always_comb begin
    buf_we_c = '0;
    for (int unsigned i = 0; i < NUM_BUFFERS; i++) begin
      if ((state_q != S_WAIT_VBL) && (write_q == IDX_W'(i))) buf_we_c[i] = bus.gpu_we;
    end
  end

  fsc_pixel_mux #(
    .DATA_W      (DATA_W),
    .NUM_BUFFERS (NUM_BUFFERS)
  ) u_pixel_mux (
    .rd_data_i (bus.buf_rd_data),
    .sel_i     (disp_q),
    .blank_i   (bus.vga_blank),
    .pix_c     (pix_c)
  );

  assign bus.buf_we    = buf_we_c;
  assign bus.gpu_start = gpu_start_q;
  assign bus.write_idx = write_q;
  assign bus.disp_idx  = disp_q;
  assign bus.vga_r     = pix_c;
  assign bus.vga_g     = pix_c;
  assign bus.vga_b     = pix_c;

`ifdef FRAME_STATS_EN
  logic [STAT_W-1:0] frame_q, frame_d;
  logic [STAT_W-1:0] drop_q, drop_d;

  // Saturating statistics counters.
  always_comb begin
    frame_d = frame_q;
    drop_d  = drop_q;
    if (frame_inc && (frame_q != '1)) frame_d = frame_q + STAT_W'(1);
    if (drop_inc && (drop_q != '1))   drop_d  = drop_q + STAT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      frame_q <= '0;
      drop_q  <= '0;
    end else begin
      frame_q <= frame_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.frame_count = frame_q;
  assign bus.drop_count  = drop_q;
`else
  logic unused_stats;
  assign unused_stats    = frame_inc ^ drop_inc;
  assign bus.frame_count = '0;
  assign bus.drop_count  = '0;
`endif

endmodule

// File: doc/frame_swap_controller.md
Name: frame_swap_controller

Overview:
- Single-clock, parametrised successor to the double-buffer frame director. Manages 2 or 3 frame buffers (double or triple buffering) between GPU renderer and VGA scan-out.
- Owns buffer roles (display / write / ready), gpu_start/gpu_done handshake, vblank-synchronised swaps, per-buffer write-enable steering and blank-gated pixel mux.
- Sits between gpu core, frame_buffer instances and vga_controller.

Parameters:
- DATA_W, 4, pixel width in bits.
- NUM_BUFFERS, 2, buffer count; only 2 (double) or 3 (triple) is legal. Any other value triggers an elaboration $error.
- STAT_W, 16, width of the statistics counters.

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- Reset  input  1  synchronous, active-low reset.
- vga_vs  input  1  VGA vertical sync from vga_controller, synchronous to Clk.
- vga_blank  input  1  1 = active display region, 0 = porch/sync.
- gpu_we  input  1  GPU pixel write strobe.
- gpu_done  input  1  one-cycle pulse: current write buffer fully rendered.
- buf_rd_data  input  NUM_BUFFERS*DATA_W  packed read data; buffer i occupies bits [i*DATA_W +: DATA_W].
- buf_we  output  NUM_BUFFERS  one-hot-or-zero write enables to the buffers.
- gpu_start  output  1  one-cycle pulse: begin rendering into write_idx.
- write_idx  output  2  index of the buffer the GPU writes.
- disp_idx  output  2  index of the buffer being scanned out.
- vga_r, vga_g, vga_b  output  DATA_W each  grayscale pixel, replicated to all three channels.
- frame_count  output  STAT_W  swaps performed.
- drop_count  output  STAT_W  rendered frames discarded.

Behaviour:
- Vblank event (vbl): rising edge of vga_vs, detected with one registered copy of vga_vs. The edge register resets to 1 so no event fires in the first cycle after reset.
- Reset values (Reset=0):
  - disp_idx=0, write_idx=1, ready_valid=0, ready_idx=2 (unused when NUM_BUFFERS=2).
  - gpu_start=0, counters=0, state=S_START.
- FSM:
  - S_START: drive gpu_start=1 for exactly one cycle, then go to S_RENDER.
  - S_RENDER, on gpu_done, NUM_BUFFERS=2: go to S_WAIT_VBL.
  - S_RENDER, on gpu_done, NUM_BUFFERS=3:
    - If !ready_valid: ready_idx<=write_idx, ready_valid<=1, write_idx<=the free index (neither disp nor write).
    - If ready_valid: swap write_idx and ready_idx (newest frame becomes ready; old ready buffer is reused) and increment drop_count.
    - Either way, go to S_START.
  - S_WAIT_VBL (double only), on vbl: disp_idx<=write_idx, write_idx<=old disp_idx, frame_count++, go to S_START.
- Triple-mode vbl handling, in any state: if ready_valid, then disp_idx<=ready_idx, ready_idx<=old disp_idx, ready_valid<=0, frame_count++. If !ready_valid, disp_idx is held and the frame repeats.
- Simultaneous vbl and gpu_done:
  - Double mode, S_RENDER: gpu_done moves to S_WAIT_VBL. That cycle's vbl is not consumed; the swap waits for the next vbl.
  - Triple mode: vbl swap is applied first, then gpu_done using the updated indices. If ready was just consumed, the finished frame becomes ready with no drop.
- gpu_done outside S_RENDER: ignored.
- vbl in S_START or S_RENDER (double mode): no effect.
- Write steering:
  - buf_we[write_idx]=gpu_we in S_RENDER and S_START; all other bits 0.
  - In S_WAIT_VBL all buf_we=0, which protects the completed frame.
- Pixel path (combinational, zero latency): sel = buf_rd_data slice at disp_idx; vga_r/g/b = vga_blank ? sel : 0.
- Invariant: disp_idx != write_idx always. In triple mode, the three roles are distinct whenever ready_valid=1.
- Counters saturate at all-ones and do not wrap.
- Reset asserted mid-frame: all state returns to reset values on the next edge. A pending ready frame is discarded without counting a drop.

Optional Feature:
- FRAME_STATS_EN defined: frame_count and drop_count are implemented as specified.
- FRAME_STATS_EN undefined: both outputs are tied to 0 and no counter flops are built. Ports remain present.

Decomposition:
- Package fsc_pkg:
  - state enum fsc_state_e {S_START, S_RENDER, S_WAIT_VBL}.
  - localparam IDX_W=2.
  - function free_idx(a,b) returning the third index.
- One sub-module: fsc_pixel_mux (indexed slice select plus blank gating, parametrised by DATA_W and NUM_BUFFERS).

Test Plan:
- Reset release, NUM_BUFFERS=2 -> gpu_start high exactly one cycle after Reset rises; disp_idx=0, write_idx=1; buf_we=2'b10 when gpu_we=1.
- Double mode, gpu_done pulse, then vga_vs rises 20 cycles later -> buf_we=0 during the wait; on vbl disp_idx=1, write_idx=0; gpu_start pulses the next cycle; frame_count=1.
- Triple mode, two gpu_done pulses with no vbl -> first: ready_idx=1, write_idx=2. Second: ready_idx=2, write_idx=1, drop_count=1. Next vbl: disp_idx=2, ready_idx=0, ready_valid=0.
- Triple mode, gpu_done and vbl in the same cycle with ready_valid=1, ready_idx=1 -> disp_idx=1, finished buffer 2 becomes ready, write_idx=0, drop_count unchanged.
- vga_blank=0 with buf_rd_data slice for disp_idx = 4'hA -> vga_r/g/b=0. With vga_blank=1 -> 4'hA on all three channels.
- Counter saturation (FRAME_STATS_EN, STAT_W=4): 20 swaps -> frame_count=4'hF. Without the macro -> frame_count=0 throughout.
